gauss_line_buffer: RTL and testbench



---
 rtl/gauss_line_buffer.sv | 171 +++++++++++++++++
 tb/tb_gauss_line_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gauss_line_buffer.sv
// Raster pixel stream to 3x3 vertical columns (top/mid/bot) with border flags; flushes last row itself.
// Optional build macro: BORDER_REPLICATE_EN (missing rows replicate mid instead of 0).
module gauss_line_buffer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic       in_ready,
  output logic [7:0] top,
  output logic [7:0] mid,
  output logic [7:0] bot,
  output logic       valid_out,
  output logic       top_edge,
  output logic       bot_edge,
  output logic       left_edge,
  output logic       right_edge,
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_line_a [IMG_W];
  logic [7:0]      r_line_b [IMG_W];
  logic            r_in_ready;
  logic [7:0]      r_top, r_mid, r_bot;
  logic            r_vld, r_tedge, r_bedge, r_ledge, r_redge, r_done;

  logic            w_accept, w_col_last, w_row_last, w_wr_a, w_wr_b, w_adv;
  logic [7:0]      w_rd_a, w_rd_b, w_top, w_mid, w_bot;
  logic            w_vld, w_tedge, w_bedge, w_ledge, w_redge, w_done;

  assign w_accept   = valid_in & r_in_ready & ~rst;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_rd_a     = r_line_a[r_col];
  assign w_rd_b     = r_line_b[r_col];
  assign w_adv      = w_accept | (r_state == S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_a  = 1'b0;
    w_wr_b  = 1'b0;
    w_vld   = 1'b0;
    w_top   = 8'd0;
    w_mid   = 8'd0;
    w_bot   = 8'd0;
    w_tedge = 1'b0;
    w_bedge = 1'b0;
    w_ledge = 1'b0;
    w_redge = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (w_accept) begin
          w_wr_b = 1'b1;
          if (w_col_last) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_wr_a  = 1'b1;
          w_wr_b  = 1'b1;
          w_vld   = 1'b1;
          w_mid   = w_rd_b;
          w_bot   = pixel_in;
          w_tedge = (r_row == ROW_ONE);
          w_ledge = (r_col == '0);
          w_redge = w_col_last;
          // lineA is stale while the centre row is 0
`ifdef BORDER_REPLICATE_EN
          w_top   = w_tedge ? w_rd_b : w_rd_a;
`else
          w_top   = w_tedge ? 8'd0 : w_rd_a;
`endif
          if (w_col_last && w_row_last) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_vld   = 1'b1;
        w_top   = w_rd_a;
        w_mid   = w_rd_b;
`ifdef BORDER_REPLICATE_EN
        w_bot   = w_rd_b;
`else
        w_bot   = 8'd0;
`endif
        w_bedge = 1'b1;
        w_ledge = (r_col == '0);
        w_redge = w_col_last;
        w_done  = w_col_last;
        if (w_col_last) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_adv) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= ((r_state == S_FLUSH) || w_row_last) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line memories are intentionally not reset: FILL rewrites row 0 before any read reaches the output.
  always_ff @(posedge clk) begin
    if (w_wr_a) r_line_a[r_col] <= w_rd_b;
    if (w_wr_b) r_line_b[r_col] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b1;
      r_vld      <= 1'b0;
      r_top      <= 8'd0;
      r_mid      <= 8'd0;
      r_bot      <= 8'd0;
      r_tedge    <= 1'b0;
      r_bedge    <= 1'b0;
      r_ledge    <= 1'b0;
      r_redge    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != S_FLUSH);
      r_vld      <= w_vld;
      r_top      <= w_top;
      r_mid      <= w_mid;
      r_bot      <= w_bot;
      r_tedge    <= w_tedge;
      r_bedge    <= w_bedge;
      r_ledge    <= w_ledge;
      r_redge    <= w_redge;
      r_done     <= w_done;
    end
  end

  assign in_ready   = r_in_ready;
  assign valid_out  = r_vld;
  assign top        = r_top;
  assign mid        = r_mid;
  assign bot        = r_bot;
  assign top_edge   = r_tedge;
  assign bot_edge   = r_bedge;
  assign left_edge  = r_ledge;
  assign right_edge = r_redge;
  assign frame_done = r_done;

endmodule

// File: tb/tb_gauss_line_buffer.sv
// Directed bench for gauss_line_buffer at IMG_W=4, IMG_H=3 with pixel(r,c)=16r+c+1.
module tb_gauss_line_buffer;

  localparam int W = 4;
  localparam int H = 3;
`ifdef BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pixel_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       in_ready, valid_out, top_edge, bot_edge, left_edge, right_edge, frame_done;
  logic [7:0] top, mid, bot;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic       te;
    logic       be;
    logic       le;
    logic       re;
    logic       fd;
  } col_t;

  typedef struct packed {
    logic [7:0] pix_in;
    col_t       exp;
  } vec_t;

  vec_t tbl [12];
  col_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  gauss_line_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .in_ready(in_ready),
    .top(top), .mid(mid), .bot(bot), .valid_out(valid_out),
    .top_edge(top_edge), .bot_edge(bot_edge), .left_edge(left_edge), .right_edge(right_edge),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic col_t cur();
    return {top, mid, bot, top_edge, bot_edge, left_edge, right_edge, frame_done};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      q.push_back(cur());
      if (frame_done) n_done++;
    end else if (!rst) begin
      chk("idle_flags", {59'd0, top_edge, bot_edge, left_edge, right_edge, frame_done}, 64'd0);
    end
  end

  task automatic send(input logic [7:0] p);
    int t;
    t = 0;
    pixel_in = p;
    valid_in = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_ncols"}, q.size(), 12);
    chk({nm, "_ndone"}, n_done, 1);
    for (int i = 0; i < 12; i++) begin
      if (i < q.size()) chk($sformatf("%s_col%0d", nm, i), q[i], tbl[i].exp);
    end
  endtask

  task automatic run_frame(input string nm, input bit gaps, input bit hold, input bit detail);
    q.delete();
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        valid_in = 1'b0;
        @(negedge clk);
      end
      send(tbl[i].pix_in);
      if (detail && i == 3) chk("row0_no_output", q.size(), 0);
      if (detail && i == 4) chk("first_col", {valid_out, cur()}, {1'b1, tbl[0].exp});
      if (detail && i == 11) begin
        valid_in = 1'b0;
        chk("last_run_col", {valid_out, cur()}, {1'b1, tbl[7].exp});
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("flush_ready_low%0d", k), {63'd0, in_ready}, 64'd0);
          @(negedge clk);
        end
        chk("ready_back", {63'd0, in_ready}, 64'd1);
        chk("final_col", {valid_out, cur()}, {1'b1, tbl[11].exp});
      end
    end
    if (hold) begin
      pixel_in = 8'hEE;
      repeat (4) @(negedge clk);
    end
    valid_in = 1'b0;
    repeat (6) @(negedge clk);
    check_frame(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 12; i++) begin
      int r, c;
      logic [7:0] m;
      r = i / W;
      c = i % W;
      m = 8'(16 * r + c + 1);
      tbl[i].pix_in = m;
      tbl[i].exp.mid = m;
      tbl[i].exp.top = (r == 0) ? (REP ? m : 8'd0) : 8'(16 * (r - 1) + c + 1);
      tbl[i].exp.bot = (r == H - 1) ? (REP ? m : 8'd0) : 8'(16 * (r + 1) + c + 1);
      tbl[i].exp.te  = (r == 0);
      tbl[i].exp.be  = (r == H - 1);
      tbl[i].exp.le  = (c == 0);
      tbl[i].exp.re  = (c == W - 1);
      tbl[i].exp.fd  = (r == H - 1) && (c == W - 1);
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {valid_out, cur()}, 64'd0);
    chk("reset_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    run_frame("clean", 1'b0, 1'b0, 1'b1);
    run_frame("gaps_hold", 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) send(tbl[i].pix_in);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_outputs", {valid_out, cur()}, 64'd0);
    chk("midreset_ready", {63'd0, in_ready}, 64'd1);
    run_frame("after_reset", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
